// File: rtl/aes_key_expand.sv
// aes_key_expand: AES-128/192/256 key schedule, one word per cycle.
// Optional: define AES_KEY_EXP_EXT_RCON_EN to take rcon from port r_con_i.
module aes_key_expand #(
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         clr,
  input  logic         start,
  input  logic [255:0] key_i,
`ifdef AES_KEY_EXP_EXT_RCON_EN
  input  logic [7:0]   r_con_i,
`endif
  output logic [31:0]  Sub_o,
  input  logic [31:0]  Sub_i,
  output logic [127:0] key_o,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);

  localparam int         W     = NK * 32;
  localparam logic [3:0] NR    = 4'(NK + 6);
  localparam logic [5:0] TOT   = 6'(4 * (NK + 7));
  localparam logic [5:0] NKW   = 6'(NK);
  localparam logic [2:0] MLAST = 3'(NK - 1);
  localparam logic       IDLE  = 1'b0;
  localparam logic       RUN   = 1'b1;

  logic         state_q, state_d;
  logic [W-1:0] win_q, win_d;
  logic [5:0]   i_q, i_d;
  logic [2:0]   m_q, m_d;
  logic [127:0] col_q, col_d;
  logic [3:0]   idx_q, idx_d;
  logic         vld_q, vld_d;
  logic [7:0]   rc;
`ifndef AES_KEY_EXP_EXT_RCON_EN
  logic [7:0]   rcon_q, rcon_d;
`endif

  logic [31:0]  w_old, w_prev, w_rot;
  logic [31:0]  temp, w_new;
  logic         gen, pre, accept;
  logic         sub_rc, sub_h;
  logic         unused_key;

  // Only the top NK words of key_i feed the window.
  assign unused_key = ^key_i;

`ifdef AES_KEY_EXP_EXT_RCON_EN
  assign rc = r_con_i;
`else
  assign rc = rcon_q;
`endif

  // Window holds w[i-NK]..w[i-1]; oldest word at the top.
  always_comb begin
    w_old  = win_q[W-1 -: 32];
    w_prev = win_q[31:0];
    w_rot  = {w_prev[23:0], w_prev[31:24]};
    accept = vld_q & rk_ready;
    gen    = (state_q == RUN) && (i_q < TOT)
             && (!vld_q || rk_ready);
    pre    = i_q < NKW;
    sub_rc = gen && !pre && (m_q == 3'd0);
    sub_h  = gen && !pre && (NK == 8)
             && (m_q == 3'd4);
    Sub_o  = 32'h0;
    temp   = w_prev;
    unique case (1'b1)
      sub_rc: begin
        Sub_o = w_rot;
        temp  = Sub_i ^ {rc, 24'h0};
      end
      sub_h: begin
        Sub_o = w_prev;
        temp  = Sub_i;
      end
      default: ;
    endcase
    // Key words come out by rotating the captured window.
    w_new = pre ? w_old : (w_old ^ temp);
  end

  // Next-state: clr wins, start only in IDLE, gen/accept in RUN.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    i_d     = i_q;
    m_d     = m_q;
    col_d   = col_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
`ifndef AES_KEY_EXP_EXT_RCON_EN
    rcon_d  = rcon_q;
`endif
    if (clr) begin
      state_d = IDLE;
      win_d   = '0;
      i_d     = '0;
      m_d     = '0;
      col_d   = '0;
      idx_d   = '0;
      vld_d   = 1'b0;
`ifndef AES_KEY_EXP_EXT_RCON_EN
      rcon_d  = 8'h01;
`endif
    end else if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        win_d   = key_i[255 -: W];
        i_d     = '0;
        m_d     = '0;
        col_d   = '0;
        idx_d   = '0;
        vld_d   = 1'b0;
`ifndef AES_KEY_EXP_EXT_RCON_EN
        rcon_d  = 8'h01;
`endif
      end
    end else begin
      if (accept) begin
        vld_d = 1'b0;
        if (idx_q == NR) state_d = IDLE;
        else             idx_d   = idx_q + 4'd1;
      end
      if (gen) begin
        win_d = {win_q[W-33:0], w_new};
        col_d = {col_q[95:0], w_new};
        i_d   = i_q + 6'd1;
        m_d   = (m_q == MLAST) ? 3'd0 : m_q + 3'd1;
        if (i_q[1:0] == 2'd3) vld_d = 1'b1;
`ifndef AES_KEY_EXP_EXT_RCON_EN
        if (sub_rc)
          rcon_d = {rcon_q[6:0], 1'b0}
                   ^ (rcon_q[7] ? 8'h1b : 8'h00);
`endif
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      win_q   <= '0;
      i_q     <= '0;
      m_q     <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
`ifndef AES_KEY_EXP_EXT_RCON_EN
      rcon_q  <= 8'h01;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      i_q     <= i_d;
      m_q     <= m_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
`ifndef AES_KEY_EXP_EXT_RCON_EN
      rcon_q  <= rcon_d;
`endif
    end
  end

  assign key_o    = col_q;
  assign rk_idx   = idx_q;
  assign rk_valid = vld_q;
  assign busy     = (state_q == RUN);
  assign done     = vld_q & rk_ready & (idx_q == NR);

endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: NK=4/6/8 instances vs. a FIPS-197 style model.
// The S-box is built from GF(2^8) inverse plus affine map.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         nrst, clr, start, rk_ready;
  logic [255:0] keyv     [3];
  logic [31:0]  sub_o    [3];
  logic [31:0]  sub_i    [3];
  logic [127:0] key_o    [3];
  logic [3:0]   rk_idx   [3];
  logic         rk_valid [3];
  logic         busy     [3];
  logic         done     [3];

  logic [7:0]   sbox [256];
  logic [31:0]  expw [3][60];
  logic [127:0] cap  [3][16];
  logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04,
    8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  int nkv [3] = '{4, 6, 8};

  int     n_chk = 0;
  int     n_fail = 0;
  bit     rnd_mode;
  bit     run_on  [3];
  bit     stall   [3];
  int     exp_idx [3];
  int     edges   [3];
  logic [127:0] held_key [3];
  logic [3:0]   held_idx [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_sb
    assign sub_i[g] = {sbox[sub_o[g][31:24]],
      sbox[sub_o[g][23:16]], sbox[sub_o[g][15:8]],
      sbox[sub_o[g][7:0]]};
  end

  aes_key_expand #(.NK(4)) u_nk4 (
    .clk(clk), .nrst(nrst), .clr(clr), .start(start),
    .key_i(keyv[0]), .Sub_o(sub_o[0]), .Sub_i(sub_i[0]),
    .key_o(key_o[0]), .rk_idx(rk_idx[0]),
    .rk_valid(rk_valid[0]), .rk_ready(rk_ready),
    .busy(busy[0]), .done(done[0]));

  aes_key_expand #(.NK(6)) u_nk6 (
    .clk(clk), .nrst(nrst), .clr(clr), .start(start),
    .key_i(keyv[1]), .Sub_o(sub_o[1]), .Sub_i(sub_i[1]),
    .key_o(key_o[1]), .rk_idx(rk_idx[1]),
    .rk_valid(rk_valid[1]), .rk_ready(rk_ready),
    .busy(busy[1]), .done(done[1]));

  aes_key_expand #(.NK(8)) u_nk8 (
    .clk(clk), .nrst(nrst), .clr(clr), .start(start),
    .key_i(keyv[2]), .Sub_o(sub_o[2]), .Sub_i(sub_i[2]),
    .key_o(key_o[2]), .rk_idx(rk_idx[2]),
    .rk_valid(rk_valid[2]), .rk_ready(rk_ready),
    .busy(busy[2]), .done(done[2]));

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b,
                                       input int k);
    logic [15:0] t;
    t = {b, b} << k;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
                ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]],
            sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expand(input int n);
    logic [31:0] t;
    int nk;
    nk = nkv[n];
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) expw[n][i] = keyv[n][255 - 32 * i -: 32];
      else begin
        t = expw[n][i - 1];
        if (i % nk == 0)
          t = subw({t[23:0], t[31:24]})
              ^ {rcon_tab[i / nk - 1], 24'h0};
        else if (nk == 8 && i % nk == 4)
          t = subw(t);
        expw[n][i] = expw[n][i - nk] ^ t;
      end
    end
  endtask

  function automatic logic [127:0] rk_exp(input int n,
                                          input int k);
    return {expw[n][4 * k], expw[n][4 * k + 1],
            expw[n][4 * k + 2], expw[n][4 * k + 3]};
  endfunction

  task automatic monitor();
    string s;
    for (int n = 0; n < 3; n++) begin
      if (run_on[n]) begin
        s = $sformatf("nk%0d_r%0d", nkv[n], exp_idx[n]);
        check({s, "_busy"}, 128'(busy[n]), 128'(1));
        if (stall[n]) begin
          check({s, "_hold_vld"}, 128'(rk_valid[n]), 128'(1));
          check({s, "_hold_key"}, key_o[n], held_key[n]);
          check({s, "_hold_idx"}, 128'(rk_idx[n]),
                128'(held_idx[n]));
        end
        if (rk_valid[n]) begin
          check({s, "_idx"}, 128'(rk_idx[n]),
                128'(exp_idx[n]));
          check({s, "_key"}, key_o[n], rk_exp(n, exp_idx[n]));
          if (!rnd_mode)
            check({s, "_lat"}, 128'(edges[n]),
                  128'(4 * exp_idx[n] + 4));
          check({s, "_done"}, 128'(done[n]),
                128'(rk_ready && exp_idx[n] == nkv[n] + 6));
          if (rk_ready) begin
            cap[n][exp_idx[n]] = key_o[n];
            if (exp_idx[n] == nkv[n] + 6) run_on[n] = 1'b0;
            exp_idx[n]++;
            stall[n] = 1'b0;
          end else begin
            stall[n]    = 1'b1;
            held_key[n] = key_o[n];
            held_idx[n] = rk_idx[n];
          end
        end else begin
          check({s, "_done_lo"}, 128'(done[n]), 128'(0));
        end
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    for (int n = 0; n < 3; n++) if (run_on[n]) edges[n]++;
    #1;
  endtask

  task automatic chk_zero(input string tag);
    for (int n = 0; n < 3; n++) begin
      check($sformatf("%s_nk%0d_key", tag, nkv[n]),
            key_o[n], 128'(0));
      check($sformatf("%s_nk%0d_idx", tag, nkv[n]),
            128'(rk_idx[n]), 128'(0));
      check($sformatf("%s_nk%0d_vld", tag, nkv[n]),
            128'(rk_valid[n]), 128'(0));
      check($sformatf("%s_nk%0d_busy", tag, nkv[n]),
            128'(busy[n]), 128'(0));
      check($sformatf("%s_nk%0d_done", tag, nkv[n]),
            128'(done[n]), 128'(0));
      check($sformatf("%s_nk%0d_sub", tag, nkv[n]),
            128'(sub_o[n]), 128'(0));
    end
  endtask

  task automatic rand_keys();
    for (int n = 0; n < 3; n++)
      keyv[n] = {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
  endtask

  // stop_idx >= 0 returns early once NK=4 reaches that round.
  task automatic run(input bit rnd, input int stop_idx);
    bit any;
    int c;
    for (int n = 0; n < 3; n++) expand(n);
    rnd_mode = rnd;
    rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int n = 0; n < 3; n++) begin
      run_on[n]  = 1'b1;
      stall[n]   = 1'b0;
      exp_idx[n] = 0;
      edges[n]   = 0;
    end
    any = 1'b1;
    c = 0;
    while (any && c < 1000) begin
      rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (c >= 3 && c <= 5);
      if (start) rand_keys();
      cyc();
      c++;
      any = run_on[0] | run_on[1] | run_on[2];
      if (stop_idx >= 0 && int'(rk_idx[0]) == stop_idx) break;
    end
    start = 1'b0;
    if (stop_idx >= 0) begin
      check("stop_reached", 128'(rk_idx[0]),
            128'(stop_idx));
    end else begin
      check("timeout", 128'(any), 128'(0));
      for (int n = 0; n < 3; n++) begin
        check($sformatf("nk%0d_idle", nkv[n]),
              128'(busy[n]), 128'(0));
        check($sformatf("nk%0d_vld_off", nkv[n]),
              128'(rk_valid[n]), 128'(0));
      end
    end
  endtask

  initial begin
    build_sbox();
    nrst = 1'b0;
    clr = 1'b0;
    start = 1'b0;
    rk_ready = 1'b0;
    rnd_mode = 1'b0;
    for (int n = 0; n < 3; n++) begin
      keyv[n] = '0;
      run_on[n] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    nrst = 1'b1;
    @(posedge clk);
    #1;

    keyv[0] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    keyv[1] = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
               64'h0};
    keyv[2] = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    run(1'b0, -1);
    check("kat4_r1", cap[0][1],
          128'ha0fafe1788542cb123a339392a6c7605);
    check("kat4_r10", cap[0][10],
          128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("kat6_last", 128'(cap[1][12][31:0]),
          128'(32'h01002202));
    check("kat8_last", 128'(cap[2][14][31:0]),
          128'(32'h706c631e));

    repeat (3) begin
      rand_keys();
      run(1'b1, -1);
    end

    rand_keys();
    clr = 1'b1;
    start = 1'b1;
    cyc();
    clr = 1'b0;
    start = 1'b0;
    for (int n = 0; n < 3; n++)
      check($sformatf("clr_prio_nk%0d", nkv[n]),
            128'(busy[n]), 128'(0));

    rand_keys();
    run(1'b0, 3);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    for (int n = 0; n < 3; n++) run_on[n] = 1'b0;
    chk_zero("clr");
    rand_keys();
    run(1'b0, -1);

    rand_keys();
    run(1'b1, 5);
    nrst = 1'b0;
    #1;
    for (int n = 0; n < 3; n++) run_on[n] = 1'b0;
    chk_zero("nrst_mid");
    @(posedge clk);
    #1;
    nrst = 1'b1;
    rand_keys();
    run(1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
